alu_share_sched: RTL and testbench

//   Schedules one shared KGP-RISC ALU between two requesters: req0 = integer execute, req1 = branch/address unit.

---
 rtl/kgp_alu_pkg.sv | 28 ++
 rtl/alu_share_sched_rr_arb2.sv | 16 +
 rtl/alu_share_sched.sv | 156 +++++++++++++++
 tb/tb_alu_share_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared KGP-RISC ALU definitions: datapath width, op codes, flag indices
// and the scheduler state encoding.
package kgp_alu_pkg;

  localparam int unsigned XLEN = 32;

  // ALU op codes (ctrl[2:0]); ctrl[3] selects shift amount from in2 instead of shamt
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_COMP = 3'b001;
  localparam logic [2:0] OP_DIFF = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  // Bit positions inside the 3-bit {carry, neg, zero} flag vector
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;

  // Scheduler FSM encoding
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   valid0/valid1 : requester valids
//   last_grant    : requester granted most recently (0 or 1)
//   grant         : one-hot grant, all-zero when nobody is valid
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the requester that was not granted last wins
  assign grant[0] = valid0 & (~valid1 | last_grant);
  assign grant[1] = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/alu_share_sched.sv
// alu_share_sched: shares one combinational KGP-RISC ALU between the integer
// execute unit (req0) and the branch/address unit (req1).
//   req0_*/req1_* : valid/ready request channels {ctrl, in1, in2, shamt}
//   alu_*         : registered operands to the ALU, alu_out/alu_flag back
//   rsp_*         : tagged valid/ready response channel {id, data, flag}
//   stat_grant0/1 : saturating grant counters, present only when the
//                   ALU_SHARE_STATS_EN macro is defined
// One op in flight: IDLE -> EXEC (ALU evaluates) -> RESP (result held).
module alu_share_sched
  import kgp_alu_pkg::*;
#(
  parameter int unsigned XLEN = kgp_alu_pkg::XLEN,
  parameter int unsigned CW   = 4,
  parameter int unsigned SHW  = 5
`ifdef ALU_SHARE_STATS_EN
  ,
  parameter int unsigned STATW = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [CW-1:0]   req0_ctrl,
  input  logic [XLEN-1:0] req0_in1,
  input  logic [XLEN-1:0] req0_in2,
  input  logic [SHW-1:0]  req0_shamt,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [CW-1:0]   req1_ctrl,
  input  logic [XLEN-1:0] req1_in1,
  input  logic [XLEN-1:0] req1_in2,
  input  logic [SHW-1:0]  req1_shamt,
  output logic [CW-1:0]   alu_control,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [SHW-1:0]  alu_shamt,
  input  logic [XLEN-1:0] alu_out,
  input  logic [2:0]      alu_flag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic [2:0]      rsp_flag
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [STATW-1:0] stat_grant0,
  output logic [STATW-1:0] stat_grant1
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               last_grant_q;
  logic [1:0]         grant_c;
  logic               accept_win_c;
  logic               accept_c;

  logic [CW-1:0]      op_ctrl_q;
  logic [XLEN-1:0]    op_in1_q;
  logic [XLEN-1:0]    op_in2_q;
  logic [SHW-1:0]     op_shamt_q;
  logic               op_id_q;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant_c)
  );

  // New op may enter when idle, or when the held response leaves this cycle
  assign accept_win_c = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign req0_ready   = accept_win_c & grant_c[0];
  assign req1_ready   = accept_win_c & grant_c[1];
  assign accept_c     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // ALU is driven straight from the op registers
  assign alu_control = op_ctrl_q;
  assign alu_in1     = op_in1_q;
  assign alu_in2     = op_in2_q;
  assign alu_shamt   = op_shamt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = accept_c ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Op registers and round-robin history, loaded on an accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      op_ctrl_q    <= '0;
      op_in1_q     <= '0;
      op_in2_q     <= '0;
      op_shamt_q   <= '0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept_c) begin
      op_id_q      <= grant_c[1];
      last_grant_q <= grant_c[1];
      if (grant_c[1]) begin
        op_ctrl_q  <= req1_ctrl;
        op_in1_q   <= req1_in1;
        op_in2_q   <= req1_in2;
        op_shamt_q <= req1_shamt;
      end else begin
        op_ctrl_q  <= req0_ctrl;
        op_in1_q   <= req0_in1;
        op_in2_q   <= req0_in2;
        op_shamt_q <= req0_shamt;
      end
    end
  end

  // Response registers: capture in EXEC, hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
    end else if (state_q == ST_EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id_q;
      rsp_data  <= alu_out;
      rsp_flag  <= alu_flag;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SHARE_STATS_EN
  // Saturating per-requester grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else if (accept_c) begin
      if (grant_c[0] && (stat_grant0 != '1)) stat_grant0 <= stat_grant0 + STATW'(1);
      if (grant_c[1] && (stat_grant1 != '1)) stat_grant1 <= stat_grant1 + STATW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Self-checking bench for alu_share_sched: a behavioural ALU drives alu_out,
// directed vectors and corner sequences run first, then randomized traffic
// is compared against a transaction-level scheduler model.
module tb_alu_share_sched;
  import kgp_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl, alu_control;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2, alu_in1, alu_in2, alu_out, rsp_data;
  logic [4:0]  req0_shamt, req1_shamt, alu_shamt;
  logic [2:0]  alu_flag, rsp_flag;
  logic        rsp_valid, rsp_ready, rsp_id;
`ifdef ALU_SHARE_STATS_EN
  logic [3:0]  stat_grant0, stat_grant1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef ALU_SHARE_STATS_EN
  alu_share_sched #(.STATW(4)) dut (
`else
  alu_share_sched dut (
`endif
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_shamt(req1_shamt),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag)
`ifdef ALU_SHARE_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
  );

  // Behavioural ALU: returns {flags, result}
  function automatic logic [34:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] w;
    logic [31:0] r;
    logic        cy;
    logic [4:0]  s;
    logic [2:0]  f;
    s  = c[3] ? b[4:0] : sh;
    cy = 1'b0;
    r  = 32'd0;
    w  = 33'd0;
    case (c[2:0])
      OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32]; end
      OP_COMP: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_DIFF: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cy = w[32]; end
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << s;
      OP_SRL:  r = a >> s;
      OP_SRA:  r = 32'($signed(a) >>> s);
      default: r = 32'd0;
    endcase
    f = 3'b000;
    f[FLAG_ZERO]  = (r == 32'd0);
    f[FLAG_NEG]   = r[31];
    f[FLAG_CARRY] = cy;
    return {f, r};
  endfunction

  always_comb {alu_flag, alu_out} = alu_f(alu_control, alu_in1, alu_in2, alu_shamt);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_ctrl = 0; req0_in1 = 0; req0_in2 = 0; req0_shamt = 0;
    req1_ctrl = 0; req1_in1 = 0; req1_in2 = 0; req1_shamt = 0;
    rsp_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    logic [2:0]  exp_flag;   // {carry, neg, zero}
  } vec_t;

  vec_t vecs[9];

  // Scheduler reference model state
  bit          m_exec, m_rv, m_last, m_rid;
  logic [3:0]  m_ctrl;
  logic [31:0] m_in1, m_in2, m_rdata;
  logic [4:0]  m_sh;
  logic [2:0]  m_rflag;

  initial begin
    int grants[$];
    rst = 1;
    idle_inputs();

    vecs[0] = '{4'b0000, 32'd5,         32'd7,       5'd0, 32'd12,        3'b000};
    vecs[1] = '{4'b0010, 32'd5,         32'd7,       5'd0, 32'hFFFFFFFE,  3'b110};
    vecs[2] = '{4'b0011, 32'h0000F0F0,  32'h00000FF0, 5'd0, 32'h000000F0, 3'b000};
    vecs[3] = '{4'b0100, 32'h0000AAAA,  32'h0000AAAA, 5'd0, 32'd0,        3'b001};
    vecs[4] = '{4'b0101, 32'd1,         32'd0,       5'd4, 32'd16,        3'b000};
    vecs[5] = '{4'b0111, 32'h80000000,  32'd0,       5'd4, 32'hF8000000,  3'b010};
    vecs[6] = '{4'b1110, 32'h80000000,  32'd31,      5'd3, 32'd1,         3'b000};
    vecs[7] = '{4'b0001, 32'hFFFFFFFF,  32'd1,       5'd0, 32'd1,         3'b000};
    vecs[8] = '{4'b0000, 32'hFFFFFFFF,  32'd1,       5'd0, 32'd0,         3'b101};

    do_reset();
    // Reset state
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_alu_in1", 64'(alu_in1), 64'd0);
    chk("reset_readys", 64'({req0_ready, req1_ready}), 64'd0);

    // Directed single ops through req0, latency and result
    foreach (vecs[i]) begin
      @(negedge clk);
      req0_valid = 1; req0_ctrl = vecs[i].ctrl; req0_in1 = vecs[i].in1;
      req0_in2 = vecs[i].in2; req0_shamt = vecs[i].shamt; rsp_ready = 1;
      #1 chk($sformatf("vec%0d_ready", i), 64'(req0_ready), 64'd1);
      @(negedge clk);
      req0_valid = 0;
      chk($sformatf("vec%0d_exec_no_rsp", i), 64'(rsp_valid), 64'd0);
      chk($sformatf("vec%0d_alu_in", i), {28'd0, alu_control, alu_in1}, {28'd0, vecs[i].ctrl, vecs[i].in1});
      @(negedge clk);
      chk($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("vec%0d_rsp", i), {28'd0, rsp_flag, rsp_id, rsp_data},
          {28'd0, vecs[i].exp_flag, 1'b0, vecs[i].exp_data});
    end

    // Both valid every cycle: grants alternate starting with req0
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_in1 = 32'd10; req1_in1 = 32'd20; rsp_ready = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req0_ready && req1_ready) chk("rr_both_ready", 64'd1, 64'd0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      @(negedge clk);
    end
    if (grants.size() < 4) chk("rr_grant_count", 64'(grants.size()), 64'd4);
    else for (int g = 0; g < 4; g++) chk($sformatf("rr_grant%0d", g), 64'(grants[g]), 64'(g % 2));

    // req1 SLL held in RESP by rsp_ready=0, then back-to-back req0 accept
    do_reset();
    req1_valid = 1; req1_ctrl = 4'b0101; req1_in1 = 32'd1; req1_in2 = 32'd0; req1_shamt = 5'd4;
    rsp_ready = 0;
    #1 chk("stall_req1_ready", 64'(req1_ready), 64'd1);
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_ctrl = 4'b0000; req0_in1 = 32'd5; req0_in2 = 32'd7;
    #1 chk("stall_exec_req0_ready", 64'(req0_ready), 64'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_rsp", c), {31'd0, rsp_valid, rsp_id, rsp_data}, {31'd0, 1'b1, 1'b1, 32'd16});
      chk($sformatf("stall%0d_readys", c), 64'({req0_ready, req1_ready}), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1;
    #1 chk("b2b_req0_ready", 64'(req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 0;
    chk("b2b_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("b2b_rsp", {31'd0, rsp_valid, rsp_id, rsp_data}, {31'd0, 1'b1, 1'b0, 32'd12});

    // Reset while an op is in EXEC: op is dropped
    @(negedge clk);
    req0_valid = 1; req0_in1 = 32'd3; req0_in2 = 32'd4;
    @(negedge clk);
    req0_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_exec_alu_out_regs", {alu_in1, alu_in2}, 64'd0);
    req0_valid = 1; req1_valid = 1;
    #1 chk("rst_exec_readys", 64'({req0_ready, req1_ready}), 64'b10);
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_exec_no_rsp%0d", c), 64'(rsp_valid), 64'd0);
    end

`ifdef ALU_SHARE_STATS_EN
    // 20 req0 grants saturate a 4-bit counter
    do_reset();
    for (int c = 0; c < 20; c++) begin
      req0_valid = 1;
      @(negedge clk);
      req0_valid = 0;
      @(negedge clk);
    end
    chk("stat_grant0_sat", 64'(stat_grant0), 64'd15);
    chk("stat_grant1_zero", 64'(stat_grant1), 64'd0);
`endif

    // Randomized traffic against the scheduler model
    do_reset();
    m_exec = 0; m_rv = 0; m_last = 1; m_rid = 0;
    m_ctrl = 0; m_in1 = 0; m_in2 = 0; m_sh = 0; m_rdata = 0; m_rflag = 0;
    for (int c = 0; c < 400; c++) begin
      bit open, acc;
      int w;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_ctrl = 4'($urandom); req1_ctrl = 4'($urandom);
      req0_in1 = $urandom; req0_in2 = ($urandom_range(0, 3) == 0) ? req0_in1 : $urandom;
      req1_in1 = $urandom; req1_in2 = $urandom_range(0, 40);
      req0_shamt = 5'($urandom); req1_shamt = 5'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      open = (!m_exec && !m_rv) || (m_rv && rsp_ready);
      w = -1;
      if (req0_valid && req1_valid) w = m_last ? 0 : 1;
      else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
      acc = open && (w >= 0);
      chk($sformatf("rnd%0d_readys", c), 64'({req0_ready, req1_ready}),
          64'({acc && (w == 0), acc && (w == 1)}));
      chk($sformatf("rnd%0d_rsp_valid", c), 64'(rsp_valid), 64'(m_rv));
      if (m_rv)
        chk($sformatf("rnd%0d_rsp", c), {28'd0, rsp_flag, rsp_id, rsp_data}, {28'd0, m_rflag, m_rid, m_rdata});
      // advance model across the coming clock edge
      if (m_exec) begin
        {m_rflag, m_rdata} = alu_f(m_ctrl, m_in1, m_in2, m_sh);
        m_exec = 0;
        m_rv = 1;
      end else if (m_rv && rsp_ready) begin
        m_rv = 0;
      end
      if (acc) begin
        m_exec = 1;
        m_last = (w == 1);
        m_rid  = (w == 1);
        m_ctrl = (w == 1) ? req1_ctrl : req0_ctrl;
        m_in1  = (w == 1) ? req1_in1 : req0_in1;
        m_in2  = (w == 1) ? req1_in2 : req0_in2;
        m_sh   = (w == 1) ? req1_shamt : req0_shamt;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
